// File: rtl/pinmux_reg_bridge.sv
// Wishbone slave to pinmux register-bus initiator, one transaction in flight.
// A request the responder never acknowledges ends with a Wishbone error after TMO_CYC cycles.
module pinmux_reg_bridge #(
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 255
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [7:0]  wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        reg_cs,
    output logic        reg_wr,
    output logic [7:0]  reg_addr,
    output logic [31:0] reg_wdata,
    output logic [3:0]  reg_be,
    input  logic [31:0] reg_rdata,
    input  logic        reg_ack,
    output logic        busy,
    output logic [7:0]  tmo_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam bit             TMO_EN   = (TMO_CYC != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO_CYC == 0) ? 0 : TMO_CYC - 1);

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic [7:0]        addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       dat_q, dat_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [7:0]        tmo_count_q, tmo_count_d;

    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cs_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            dat_q       <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            tmo_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cs_q        <= cs_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            dat_q       <= dat_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            tmo_count_q <= tmo_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cs_d        = cs_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        dat_d       = dat_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        tmo_count_d = tmo_count_q;

        case (state_q)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    addr_d  = wbs_adr_i;
                    wr_d    = wbs_we_i;
                    wdata_d = wbs_dat_i;
                    be_d    = wbs_sel_i;
                    cs_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Priority: responder ack beats timeout, timeout beats master abort.
                if (reg_ack) begin
                    if (!wr_q) dat_d = reg_rdata;
                    ack_d   = 1'b1;
                    cs_d    = 1'b0;
                    state_d = RESP;
                end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
                    if (!wr_q) dat_d = '0;
                    err_d   = 1'b1;
                    cs_d    = 1'b0;
                    if (tmo_count_q != 8'hFF) tmo_count_d = tmo_count_q + 8'd1;
                    state_d = RESP;
                end else if (!wbs_cyc_i) begin
                    cs_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                // One dead cycle keeps reg_cs low between back-to-back transactions.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b0;
            end
        endcase
    end

    assign wbs_dat_o = dat_q;
    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;
    assign reg_cs    = cs_q;
    assign reg_wr    = wr_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_be    = be_q;
    assign busy      = (state_q != IDLE);
    assign tmo_count = tmo_count_q;

endmodule

// File: tb/tb_pinmux_reg_bridge.sv
// Directed table-driven bench for pinmux_reg_bridge with a 4-cycle timeout.
// Inputs are driven and outputs sampled on the falling edge.
module tb_pinmux_reg_bridge;

    logic        mclk = 1'b0;
    logic        reset;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [7:0]  wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o, wbs_err_o;
    logic        reg_cs, reg_wr;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic        busy;
    logic [7:0]  tmo_count;

    int n_cmp = 0;
    int n_bad = 0;

    pinmux_reg_bridge #(.TMO_W(8), .TMO_CYC(4)) dut (
        .mclk(mclk), .reset(reset),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
        .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_be(reg_be),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack),
        .busy(busy), .tmo_count(tmo_count)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        bit          we;
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          ack_at;    // reg_cs cycle (1-based) on which responder acks; 0 = never
        int          abort_at;  // reg_cs cycle on which master drops cyc; 0 = never
        logic [31:0] rdata;
        bit          exp_ack;
        bit          exp_err;
        logic [31:0] exp_dat;
        int          exp_cs;
        logic [7:0]  exp_tmo;
        int          exp_lat;   // cycles from strobe to ack/err pulse; 0 = none expected
    } vec_t;

    function automatic vec_t mk(bit we, logic [7:0] adr, logic [31:0] dat, logic [3:0] sel,
                                int ack_at, int abort_at, logic [31:0] rdata,
                                bit exp_ack, bit exp_err, logic [31:0] exp_dat,
                                int exp_cs, logic [7:0] exp_tmo, int exp_lat);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.sel = sel;
        v.ack_at = ack_at; v.abort_at = abort_at; v.rdata = rdata;
        v.exp_ack = exp_ack; v.exp_err = exp_err; v.exp_dat = exp_dat;
        v.exp_cs = exp_cs; v.exp_tmo = exp_tmo; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0;
        reg_ack = 1'b0; reg_rdata = 32'hDEAD_BEEF;
    endtask

    // Called on a falling edge; returns on a falling edge with the DUT back in IDLE.
    task automatic run_vec(input vec_t v, input string nm);
        int  n, cs_n, lat;
        bit  got_ack, got_err, fld_bad, aborted, done;
        n = 0; cs_n = 0; lat = 0;
        got_ack = 0; got_err = 0; fld_bad = 0; aborted = 0; done = 0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = v.we;
        wbs_adr_i = v.adr; wbs_dat_i = v.dat; wbs_sel_i = v.sel;
        while (!done && n < 40) begin
            @(negedge mclk);
            n++;
            if (reg_cs) begin
                cs_n++;
                if (reg_addr !== v.adr || reg_wr !== v.we || reg_be !== v.sel ||
                    reg_wdata !== v.dat || busy !== 1'b1)
                    fld_bad = 1;
            end
            if (wbs_ack_o || wbs_err_o) begin
                got_ack = wbs_ack_o; got_err = wbs_err_o; lat = n; done = 1;
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; reg_ack = 1'b0;
            end else if (aborted && !reg_cs && !busy) begin
                done = 1;
            end else begin
                reg_ack   = reg_cs && (v.ack_at != 0) && (cs_n == v.ack_at);
                reg_rdata = reg_ack ? v.rdata : 32'hDEAD_BEEF;
                if (reg_cs && v.abort_at != 0 && cs_n == v.abort_at) begin
                    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; aborted = 1;
                end
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: no completion within %0d cycles", nm, n);
            idle_inputs();
        end
        // The pulse must last one cycle and the FSM must be idle afterwards.
        repeat (aborted ? 3 : 1) begin
            @(negedge mclk);
            if (wbs_ack_o) got_ack = 1;
            if (wbs_err_o) got_err = 1;
            chk({nm, "_idle_after"}, 32'(busy), 32'd0);
        end
        chk({nm, "_ack"},   32'(got_ack), 32'(v.exp_ack));
        chk({nm, "_err"},   32'(got_err), 32'(v.exp_err));
        chk({nm, "_dat_o"}, wbs_dat_o, v.exp_dat);
        chk({nm, "_cs_cycles"}, 32'(cs_n), 32'(v.exp_cs));
        chk({nm, "_tmo_count"}, 32'(tmo_count), 32'(v.exp_tmo));
        chk({nm, "_req_fields"}, 32'(fld_bad), 32'd0);
        if (v.exp_lat != 0) chk({nm, "_latency"}, 32'(lat), 32'(v.exp_lat));
    endtask

    vec_t vecs[9];

    initial begin
        vec_t sv;
        int   err_seen;

        vecs[0] = mk(1, 8'h04, 32'hA5A5_0001, 4'hF, 1, 0, 32'h0,         1, 0, 32'h0000_0000, 1, 8'd0, 2);
        vecs[1] = mk(0, 8'h40, 32'h0000_0000, 4'hF, 4, 0, 32'h1234_5678, 1, 0, 32'h1234_5678, 4, 8'd0, 5);
        vecs[2] = mk(1, 8'h08, 32'hFFFF_0000, 4'h3, 2, 0, 32'h5555_5555, 1, 0, 32'h1234_5678, 2, 8'd0, 3);
        vecs[3] = mk(0, 8'h10, 32'h0000_0000, 4'hF, 0, 0, 32'h0,         0, 1, 32'h0000_0000, 4, 8'd1, 5);
        vecs[4] = mk(0, 8'h14, 32'h0000_0000, 4'hF, 4, 0, 32'hCAFE_BABE, 1, 0, 32'hCAFE_BABE, 4, 8'd1, 5);
        vecs[5] = mk(1, 8'h20, 32'h1357_9BDF, 4'hC, 0, 0, 32'h0,         0, 1, 32'hCAFE_BABE, 4, 8'd2, 5);
        vecs[6] = mk(0, 8'h30, 32'h0000_0000, 4'hF, 0, 2, 32'h0,         0, 0, 32'hCAFE_BABE, 2, 8'd2, 0);
        vecs[7] = mk(0, 8'h44, 32'h0000_0000, 4'hF, 1, 0, 32'h0BAD_F00D, 1, 0, 32'h0BAD_F00D, 1, 8'd2, 2);
        vecs[8] = mk(0, 8'h48, 32'h0000_0000, 4'h5, 3, 0, 32'h1122_3344, 1, 0, 32'h1122_3344, 3, 8'd2, 4);

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge mclk);
        reset = 1'b0;
        @(negedge mclk);
        chk("rst_outputs", {wbs_dat_o}, 32'h0);
        chk("rst_ctrl", 32'({wbs_ack_o, wbs_err_o, reg_cs, reg_wr, busy}), 32'h0);
        chk("rst_bus", {reg_addr, reg_be, tmo_count, 12'h0}, 32'h0);
        chk("rst_wdata", reg_wdata, 32'h0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Repeated timeouts: tmo_count saturates at 255.
        for (int i = 0; i < 300; i++) begin
            sv = mk(0, 8'h50, 32'h0, 4'hF, 0, 0, 32'h0, 0, 1, 32'h0, 4,
                    8'((2 + i + 1 > 255) ? 255 : 2 + i + 1), 5);
            run_vec(sv, $sformatf("sat%0d", i));
        end
        chk("sat_final", 32'(tmo_count), 32'd255);

        // Reset mid-REQ: reg_cs drops, everything clears, no ack/err ever.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 8'h0C; wbs_dat_i = 32'h7777_8888; wbs_sel_i = 4'hF;
        @(negedge mclk);
        chk("rstreq_cs_before", 32'(reg_cs), 32'd1);
        @(negedge mclk);
        reset = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        err_seen = 0;
        @(negedge mclk);
        if (wbs_ack_o || wbs_err_o) err_seen = 1;
        chk("rstreq_cs_after", 32'(reg_cs), 32'd0);
        chk("rstreq_busy", 32'(busy), 32'd0);
        chk("rstreq_tmo", 32'(tmo_count), 32'd0);
        chk("rstreq_dat", wbs_dat_o, 32'h0);
        chk("rstreq_bus", {reg_addr, reg_be, 3'b0, reg_wr, 16'h0}, 32'h0);
        reset = 1'b0;
        repeat (5) begin
            @(negedge mclk);
            if (wbs_ack_o || wbs_err_o || reg_cs) err_seen = 1;
        end
        chk("rstreq_no_pulse", 32'(err_seen), 32'd0);

        sv = mk(0, 8'h3C, 32'h0, 4'hF, 2, 0, 32'h89AB_CDEF, 1, 0, 32'h89AB_CDEF, 2, 8'd0, 3);
        run_vec(sv, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
